// File: rtl/bnn_conv_seq.sv
// bnn_conv_seq: window sequencer feeding the binary conv datapath and buffering kernel-sign results.
module bnn_conv_seq #(
  parameter int FRAME_W        = 5,
  parameter int N_KERNEL       = 3,
  parameter int FRAMES_PER_WIN = 6,
  parameter int CONV_LAT       = 1,
  parameter int OUT_DEPTH      = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  input  logic                in_valid,
  input  logic [FRAME_W-1:0]  in_data,
  output logic                in_ready,
  output logic                conv_en,
  output logic [FRAME_W-1:0]  conv_data,
  input  logic [N_KERNEL-1:0] conv_res,
  output logic                out_valid,
  output logic [N_KERNEL-1:0] out_data,
  input  logic                out_ready,
  output logic                busy,
  output logic                win_done
);
  localparam int FCW = $clog2(FRAMES_PER_WIN + 1);
  localparam int CW  = $clog2(OUT_DEPTH + 1);
  localparam int PW  = OUT_DEPTH > 1 ? $clog2(OUT_DEPTH) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t              state_q, state_d;
  logic [FCW-1:0]      frame_cnt_q, frame_cnt_d;
  logic [CW-1:0]       fifo_cnt_q, fifo_cnt_d, inflight_q, inflight_d;
  logic [PW-1:0]       rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CONV_LAT-1:0] pipe_q, pipe_d;
  logic [CONV_LAT:0]   sh;
  logic                conv_en_q, conv_en_d;
  logic [FRAME_W-1:0]  conv_data_q, conv_data_d;
  logic [N_KERNEL-1:0] mem_q [OUT_DEPTH];
  logic [N_KERNEL-1:0] mem_d [OUT_DEPTH];
  logic [CW:0]         used;
  logic                accept, push, pop;
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return p == PW'(OUT_DEPTH - 1) ? '0 : p + 1'b1;
  endfunction
  assign out_valid = fifo_cnt_q != '0;
  assign out_data  = out_valid ? mem_q[rd_ptr_q] : '0;
  assign conv_en   = conv_en_q;
  assign conv_data = conv_data_q;
  assign busy      = state_q != IDLE;
  assign win_done  = state_q == DONE;
  always_comb begin
    // credits come from registered counts only; a same-cycle pop frees nothing yet
    used        = (CW+1)'(fifo_cnt_q) + (CW+1)'(inflight_q);
    in_ready    = state_q == RUN && frame_cnt_q < FCW'(FRAMES_PER_WIN) && used < (CW+1)'(OUT_DEPTH);
    accept      = in_valid && in_ready;
    push        = pipe_q[CONV_LAT-1];
    pop         = out_valid && out_ready;
    sh          = {pipe_q, conv_en_q};
    state_d     = state_q;
    frame_cnt_d = frame_cnt_q + FCW'(accept);
    conv_en_d   = accept;
    conv_data_d = accept ? in_data : conv_data_q;
    pipe_d      = sh[CONV_LAT-1:0];
    inflight_d  = inflight_q + CW'(accept) - CW'(push);
    fifo_cnt_d  = fifo_cnt_q + CW'(push) - CW'(pop);
    wr_ptr_d    = push ? nxt(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d    = pop ? nxt(rd_ptr_q) : rd_ptr_q;
    mem_d       = mem_q;
    if (push) mem_d[wr_ptr_q] = conv_res;
    case (state_q)
      IDLE: if (start) begin
        state_d     = RUN;
        frame_cnt_d = '0;
      end
      RUN:     if (frame_cnt_d == FCW'(FRAMES_PER_WIN)) state_d = DRAIN;
      DRAIN:   if (inflight_q == '0 && fifo_cnt_q == '0) state_d = DONE;
      default: state_d = IDLE;
    endcase
    if (abort) begin
      state_d     = IDLE;
      frame_cnt_d = '0;
      conv_en_d   = 1'b0;
      pipe_d      = '0;
      inflight_d  = '0;
      fifo_cnt_d  = '0;
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      frame_cnt_q <= '0;
      fifo_cnt_q  <= '0;
      inflight_q  <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      pipe_q      <= '0;
      conv_en_q   <= 1'b0;
      conv_data_q <= '0;
    end else begin
      state_q     <= state_d;
      frame_cnt_q <= frame_cnt_d;
      fifo_cnt_q  <= fifo_cnt_d;
      inflight_q  <= inflight_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      pipe_q      <= pipe_d;
      conv_en_q   <= conv_en_d;
      conv_data_q <= conv_data_d;
    end
  end
  always_ff @(posedge clk) mem_q <= mem_d;
  always_ff @(posedge clk) if (rst_n && !abort) assert (!(push && !pop && fifo_cnt_q == CW'(OUT_DEPTH)));
endmodule

// File: tb/tb_bnn_conv_seq.sv
// tb_bnn_conv_seq: drives CONV_LAT=1 and CONV_LAT=3 sequencers in parallel against a frame-order scoreboard.
module tb_bnn_conv_seq;
  logic clk = 0, rst_n = 0, start = 0, abort = 0, in_valid = 0, out_ready = 0;
  logic [4:0] in_data = 0;
  logic       in_ready [2], conv_en [2], out_valid [2], busy [2], win_done [2];
  logic [4:0] conv_data [2];
  logic [2:0] conv_res [2], out_data [2];
  int tests = 0, fails = 0, win_exp = 0;
  logic [2:0] exp_mem [2][64];
  int exp_wr [2] = '{0, 0}, exp_rd [2] = '{0, 0}, acc_cnt [2] = '{0, 0}, en_cnt [2] = '{0, 0}, wd_cnt [2] = '{0, 0};
  bit prev_wd [2] = '{0, 0};
  always #5 clk = ~clk;
  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int LAT = g == 0 ? 1 : 3;
    logic [2:0] dl [3];
    always @(posedge clk) begin
      dl[0] <= conv_data[g][2:0];
      dl[1] <= dl[0];
      dl[2] <= dl[1];
    end
    assign conv_res[g] = dl[LAT-1];
    bnn_conv_seq #(.CONV_LAT(LAT)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready[g]),
      .conv_en(conv_en[g]), .conv_data(conv_data[g]), .conv_res(conv_res[g]),
      .out_valid(out_valid[g]), .out_data(out_data[g]), .out_ready(out_ready),
      .busy(busy[g]), .win_done(win_done[g])
    );
  end
  task automatic chk(input string tag, input int obs, input int expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask
  task automatic monitor();
    for (int d = 0; d < 2; d++) begin
      if (!rst_n || abort) begin
        exp_rd[d] = exp_wr[d];
        acc_cnt[d] = 0;
        en_cnt[d] = 0;
        prev_wd[d] = 0;
      end else begin
        if (prev_wd[d]) chk($sformatf("busy_fall%0d", d), int'(busy[d]), 0);
        prev_wd[d] = win_done[d];
        if (in_ready[d]) chk($sformatf("credit%0d", d), int'(exp_wr[d] - exp_rd[d] < 2), 1);
        if (out_valid[d] && out_ready) begin
          chk($sformatf("pop_has_item%0d", d), int'(exp_wr[d] != exp_rd[d]), 1);
          chk($sformatf("out_data%0d", d), int'(out_data[d]), int'(exp_mem[d][exp_rd[d] % 64]));
          exp_rd[d]++;
        end
        if (in_valid && in_ready[d]) begin
          exp_mem[d][exp_wr[d] % 64] = in_data[2:0];
          exp_wr[d]++;
          acc_cnt[d]++;
        end
        if (conv_en[d]) en_cnt[d]++;
        if (win_done[d]) begin
          chk($sformatf("win_frames%0d", d), acc_cnt[d], 6);
          chk($sformatf("win_conv_en%0d", d), en_cnt[d], 6);
          chk($sformatf("win_drained%0d", d), exp_wr[d] - exp_rd[d], 0);
          chk($sformatf("win_busy%0d", d), int'(busy[d]), 1);
          acc_cnt[d] = 0;
          en_cnt[d] = 0;
          wd_cnt[d]++;
        end
      end
    end
  endtask
  task automatic step();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask
  task automatic check_reset_outputs(input string tag);
    for (int d = 0; d < 2; d++)
      chk($sformatf("%s%0d", tag, d),
          int'({in_ready[d], conv_en[d], conv_data[d], out_valid[d], out_data[d], busy[d], win_done[d]}), 0);
  endtask
  task automatic pulse_start();
    start = 1;
    step();
    start = 0;
  endtask
  task automatic run_idle(input int budget, input bit rnd, input bit st_noise);
    for (int n = 0; n < budget; n++) begin
      in_data = 5'($urandom);
      if (rnd) begin
        in_valid  = ($urandom % 4) != 0;
        out_ready = ($urandom % 3) != 0;
      end
      start = st_noise && busy[0] && busy[1] && ($urandom % 2 == 1);
      step();
      if (!busy[0] && !busy[1]) begin
        start = 0;
        return;
      end
    end
    start = 0;
    chk("idle_timeout", int'(busy[0] | busy[1]), 0);
  endtask
  task automatic check_windows();
    chk("wd_count0", wd_cnt[0], win_exp);
    chk("wd_count1", wd_cnt[1], win_exp);
  endtask
  initial begin
    repeat (2) step();
    check_reset_outputs("reset");
    rst_n = 1;
    step();
    // 1: back-to-back frames, free-flowing output
    in_valid = 1;
    out_ready = 1;
    pulse_start();
    run_idle(200, 0, 0);
    win_exp++;
    check_windows();
    // 2: output stalled, only OUT_DEPTH frames get in
    out_ready = 0;
    pulse_start();
    for (int i = 0; i < 12; i++) begin
      in_data = 5'($urandom);
      step();
    end
    chk("stall_acc0", acc_cnt[0], 2);
    chk("stall_acc1", acc_cnt[1], 2);
    chk("stall_ready0", int'(in_ready[0]), 0);
    chk("stall_ready1", int'(in_ready[1]), 0);
    out_ready = 1;
    run_idle(200, 0, 0);
    win_exp++;
    check_windows();
    // 3: random valid/ready over several windows
    for (int w = 0; w < 3; w++) begin
      pulse_start();
      run_idle(400, 1, 0);
      win_exp++;
    end
    check_windows();
    // 4: abort with a result still pending
    in_valid = 1;
    out_ready = 1;
    pulse_start();
    for (int i = 0; i < 40 && acc_cnt[0] < 3; i++) begin
      in_data = 5'($urandom);
      step();
    end
    chk("abort_acc", acc_cnt[0], 3);
    in_valid = 0;
    out_ready = 0;
    repeat (3) step();
    chk("abort_pending", int'(out_valid[0]), 1);
    abort = 1;
    step();
    abort = 0;
    chk("abort_busy", int'(busy[0]), 0);
    chk("abort_out_valid", int'(out_valid[0]), 0);
    chk("abort_conv_en", int'(conv_en[0]), 0);
    chk("abort_win_done", int'(win_done[0]), 0);
    chk("abort_busy1", int'(busy[1]), 0);
    step();
    check_windows();
    in_valid = 1;
    out_ready = 1;
    pulse_start();
    run_idle(200, 1, 0);
    win_exp++;
    check_windows();
    // 5: stray start pulses mid-window, then start+abort in IDLE
    in_valid = 1;
    out_ready = 1;
    pulse_start();
    run_idle(300, 1, 1);
    win_exp++;
    check_windows();
    start = 1;
    abort = 1;
    step();
    start = 0;
    abort = 0;
    chk("start_abort0", int'(busy[0]), 0);
    chk("start_abort1", int'(busy[1]), 0);
    step();
    // 6: asynchronous reset mid-window
    in_valid = 1;
    out_ready = 1;
    pulse_start();
    repeat (3) step();
    #2 rst_n = 0;
    #1 check_reset_outputs("async_rst");
    step();
    #2 rst_n = 1;
    step();
    pulse_start();
    run_idle(300, 1, 0);
    win_exp++;
    check_windows();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
